// File: rtl/dl11_serial_if.sv
// VM1 MPI bus responder port bundle for the DL11 serial block.
// The master drives address/strobes/data; the responder returns read data and rply.
interface dl11_serial_if;
    logic [15:0] bus_addr;
    logic        bus_sync;
    logic        bus_stb;
    logic        bus_we;
    logic [1:0]  bus_wtbt;
    logic [15:0] bus_din;
    logic [15:0] bus_dout;
    logic        bus_ack;

    modport master (
        output bus_addr, bus_sync, bus_stb, bus_we, bus_wtbt, bus_din,
        input  bus_dout, bus_ack
    );

    modport slave (
        input  bus_addr, bus_sync, bus_stb, bus_we, bus_wtbt, bus_din,
        output bus_dout, bus_ack
    );
endinterface

// File: rtl/dl11_serial.sv
// DL11-compatible serial port: RCSR/RBUF/XCSR/XBUF on the MPI bus with 8N1 RX/TX engines.
// Read data is OR-merged by the CPU, so bus_dout is zero whenever this block is not being read.
module dl11_serial #(
    parameter logic [15:0] BASE_ADDR = 16'o177560,
    parameter int          BAUD_DIV  = 5000
) (
    input  logic         clk_sys,
    input  logic         reset_n,
    input  logic         ce,
    dl11_serial_if.slave bus,
    input  logic         uart_rxd,
    output logic         uart_txd,
    output logic         irq_rx,
    output logic         irq_tx
);

    localparam int                CNT_W    = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0]  BIT_END  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0]  HALF_END = CNT_W'(BAUD_DIV / 2 - 1);

    localparam logic [1:0] REG_RCSR = 2'd0;
    localparam logic [1:0] REG_RBUF = 2'd1;
    localparam logic [1:0] REG_XCSR = 2'd2;
    localparam logic [1:0] REG_XBUF = 2'd3;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Bus handshake state
    logic        busy_r;
    logic        ack_r;
    logic [15:0] rd_hold_r;

    // Register file
    logic        rx_done_r;
    logic        rx_ie_r;
    logic        rx_ovr_r;
    logic        rx_frm_r;
    logic [7:0]  rbuf_r;
    logic        tx_ready_r;
    logic        tx_ie_r;
    logic        tx_brk_r;

    // TX engine
    tx_state_t        tx_state_r;
    tx_state_t        tx_next_s;
    logic [CNT_W-1:0] tx_cnt_r;
    logic [2:0]       tx_bit_r;
    logic [7:0]       tx_shift_r;
    logic             tx_bit_end_s;
    logic             tx_end_s;
    logic             tx_line_s;
    logic             txd_r;

    // RX engine
    logic             rxd_meta_r;
    logic             rxd_sync_r;
    logic             rxd_prev_r;
    rx_state_t        rx_state_r;
    rx_state_t        rx_next_s;
    logic [CNT_W-1:0] rx_cnt_r;
    logic [2:0]       rx_bit_r;
    logic [7:0]       rx_shift_r;
    logic             rx_fall_s;
    logic             rx_half_s;
    logic             rx_bit_end_s;
    logic             rx_done_s;

    // Decode and access qualification
    logic        sel_s;
    logic [1:0]  reg_s;
    logic        start_s;
    logic        wr_start_s;
    logic        rbuf_rd_s;
    logic        tx_load_s;
    logic [15:0] reg_val_s;
    logic        unused_s;

    assign sel_s      = bus.bus_sync & (bus.bus_addr[15:3] == BASE_ADDR[15:3]);
    assign reg_s      = bus.bus_addr[2:1];
    assign start_s    = ce & sel_s & bus.bus_stb & ~busy_r;
    assign wr_start_s = start_s & bus.bus_we;
    assign rbuf_rd_s  = start_s & ~bus.bus_we & (reg_s == REG_RBUF);
    assign tx_load_s  = wr_start_s & (reg_s == REG_XBUF) & bus.bus_wtbt[0] & tx_ready_r;
    assign unused_s   = ^{bus.bus_addr[0], bus.bus_wtbt[1], bus.bus_din[15:8]};

    assign bus.bus_ack = ack_r;
    assign uart_txd    = txd_r;
    assign irq_rx      = rx_ie_r & rx_done_r;
    assign irq_tx      = tx_ie_r & tx_ready_r;

    // Live register read mux
    always_comb begin
        reg_val_s = 16'h0000;
        case (reg_s)
            REG_RCSR: reg_val_s = {8'h00, rx_done_r, rx_ie_r, 6'h00};
            REG_RBUF: reg_val_s = {rx_ovr_r | rx_frm_r, rx_ovr_r, rx_frm_r, 5'h00, rbuf_r};
            REG_XCSR: reg_val_s = {8'h00, tx_ready_r, tx_ie_r, 5'h00, tx_brk_r};
            REG_XBUF: reg_val_s = 16'h0000;
            default:  reg_val_s = 16'h0000;
        endcase
    end

    // Read data: live value until the access starts, then the snapshot taken before side effects
    always_comb begin
        bus.bus_dout = 16'h0000;
        if (sel_s & bus.bus_stb & ~bus.bus_we) begin
            if (busy_r) begin
                bus.bus_dout = rd_hold_r;
            end else begin
                bus.bus_dout = reg_val_s;
            end
        end else begin
            bus.bus_dout = 16'h0000;
        end
    end

    // Bus handshake: one access per strobe, rply one ce after start, released after strobe drops
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            busy_r    <= 1'b0;
            ack_r     <= 1'b0;
            rd_hold_r <= 16'h0000;
        end else if (ce) begin
            if (start_s) begin
                busy_r    <= 1'b1;
                rd_hold_r <= reg_val_s;
            end else if (busy_r & bus.bus_stb) begin
                ack_r <= 1'b1;
            end else if (busy_r) begin
                busy_r <= 1'b0;
                ack_r  <= 1'b0;
            end
        end
    end

    // Register file: RX completion is applied after the RBUF read clear so it wins a tie
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            rx_done_r  <= 1'b0;
            rx_ie_r    <= 1'b0;
            rx_ovr_r   <= 1'b0;
            rx_frm_r   <= 1'b0;
            rbuf_r     <= 8'h00;
            tx_ready_r <= 1'b1;
            tx_ie_r    <= 1'b0;
            tx_brk_r   <= 1'b0;
        end else begin
            if (rbuf_rd_s) begin
                rx_done_r <= 1'b0;
                rx_ovr_r  <= 1'b0;
                rx_frm_r  <= 1'b0;
            end
            if (rx_done_s) begin
                rbuf_r    <= rx_shift_r;
                rx_done_r <= 1'b1;
                rx_frm_r  <= ~rxd_sync_r;
                rx_ovr_r  <= rx_done_r & ~rbuf_rd_s;
            end
            if (wr_start_s & bus.bus_wtbt[0]) begin
                case (reg_s)
                    REG_RCSR: rx_ie_r <= bus.bus_din[6];
                    REG_XCSR: begin
                        tx_ie_r  <= bus.bus_din[6];
                        tx_brk_r <= bus.bus_din[0];
                    end
                    default: begin
                    end
                endcase
            end
            if (tx_load_s) begin
                tx_ready_r <= 1'b0;
            end else if (tx_end_s) begin
                tx_ready_r <= 1'b1;
            end
        end
    end

    assign tx_bit_end_s = (tx_cnt_r == BIT_END);
    assign tx_end_s     = (tx_state_r == TX_STOP) & tx_bit_end_s;

    // TX state register
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            tx_state_r <= TX_IDLE;
        end else begin
            tx_state_r <= tx_next_s;
        end
    end

    // TX next-state and line level
    always_comb begin
        tx_next_s = tx_state_r;
        tx_line_s = 1'b1;
        case (tx_state_r)
            TX_IDLE: begin
                if (tx_load_s) tx_next_s = TX_START;
                else           tx_next_s = TX_IDLE;
            end
            TX_START: begin
                tx_line_s = 1'b0;
                if (tx_bit_end_s) tx_next_s = TX_DATA;
                else              tx_next_s = TX_START;
            end
            TX_DATA: begin
                tx_line_s = tx_shift_r[0];
                if (tx_bit_end_s && (tx_bit_r == 3'd7)) tx_next_s = TX_STOP;
                else                                    tx_next_s = TX_DATA;
            end
            TX_STOP: begin
                if (tx_bit_end_s) tx_next_s = TX_IDLE;
                else              tx_next_s = TX_STOP;
            end
            default: tx_next_s = TX_IDLE;
        endcase
    end

    // TX baud counter, shifter and registered serial output
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            tx_cnt_r   <= '0;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'h00;
            txd_r      <= 1'b1;
        end else begin
            if ((tx_next_s != tx_state_r) || tx_bit_end_s) begin
                tx_cnt_r <= '0;
            end else begin
                tx_cnt_r <= tx_cnt_r + CNT_W'(1);
            end
            if (tx_load_s) begin
                tx_shift_r <= bus.bus_din[7:0];
                tx_bit_r   <= 3'd0;
            end else if ((tx_state_r == TX_DATA) && tx_bit_end_s) begin
                tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                tx_bit_r   <= tx_bit_r + 3'd1;
            end
            txd_r <= ~tx_brk_r & tx_line_s;
        end
    end

    assign rx_fall_s    = rxd_prev_r & ~rxd_sync_r;
    assign rx_half_s    = (rx_cnt_r == HALF_END);
    assign rx_bit_end_s = (rx_cnt_r == BIT_END);
    assign rx_done_s    = (rx_state_r == RX_STOP) & rx_bit_end_s;

    // RX input synchroniser and edge history
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            rxd_meta_r <= 1'b1;
            rxd_sync_r <= 1'b1;
            rxd_prev_r <= 1'b1;
        end else begin
            rxd_meta_r <= uart_rxd;
            rxd_sync_r <= rxd_meta_r;
            rxd_prev_r <= rxd_sync_r;
        end
    end

    // RX state register
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            rx_state_r <= RX_IDLE;
        end else begin
            rx_state_r <= rx_next_s;
        end
    end

    // RX next-state: start bit is re-checked at mid-bit to reject glitches
    always_comb begin
        rx_next_s = rx_state_r;
        case (rx_state_r)
            RX_IDLE: begin
                if (rx_fall_s) rx_next_s = RX_START;
                else           rx_next_s = RX_IDLE;
            end
            RX_START: begin
                if (rx_half_s) begin
                    if (!rxd_sync_r) rx_next_s = RX_DATA;
                    else             rx_next_s = RX_IDLE;
                end else begin
                    rx_next_s = RX_START;
                end
            end
            RX_DATA: begin
                if (rx_bit_end_s && (rx_bit_r == 3'd7)) rx_next_s = RX_STOP;
                else                                    rx_next_s = RX_DATA;
            end
            RX_STOP: begin
                if (rx_bit_end_s) rx_next_s = RX_IDLE;
                else              rx_next_s = RX_STOP;
            end
            default: rx_next_s = RX_IDLE;
        endcase
    end

    // RX baud counter and LSB-first data shifter
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            rx_cnt_r   <= '0;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h00;
        end else begin
            if ((rx_next_s != rx_state_r) || rx_bit_end_s) begin
                rx_cnt_r <= '0;
            end else begin
                rx_cnt_r <= rx_cnt_r + CNT_W'(1);
            end
            if (rx_state_r == RX_START) begin
                rx_bit_r <= 3'd0;
            end else if ((rx_state_r == RX_DATA) && rx_bit_end_s) begin
                rx_shift_r <= {rxd_sync_r, rx_shift_r[7:1]};
                rx_bit_r   <= rx_bit_r + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_dl11_serial.sv
// Self-checking bench for dl11_serial: bus register access, TX/RX framing, overrun/framing, resets.
// Expected register values come from a small register-level model updated per bus/serial event.
module tb_dl11_serial;

    localparam int          B      = 16;
    localparam logic [15:0] A_RCSR = 16'o177560;
    localparam logic [15:0] A_RBUF = 16'o177562;
    localparam logic [15:0] A_XCSR = 16'o177564;
    localparam logic [15:0] A_XBUF = 16'o177566;

    logic clk_sys  = 1'b0;
    logic reset_n  = 1'b0;
    logic ce       = 1'b0;
    logic uart_rxd = 1'b1;
    logic uart_txd;
    logic irq_rx;
    logic irq_tx;

    int n_cmp = 0;
    int n_err = 0;

    bit       m_done, m_ovr, m_frm, m_rx_ie, m_tx_ie, m_brk, m_ready;
    bit [7:0] m_rbuf;

    dl11_serial_if bus_if();

    dl11_serial #(.BASE_ADDR(16'o177560), .BAUD_DIV(B)) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .ce      (ce),
        .bus     (bus_if),
        .uart_rxd(uart_rxd),
        .uart_txd(uart_txd),
        .irq_rx  (irq_rx),
        .irq_tx  (irq_tx)
    );

    always #5 clk_sys = ~clk_sys;

    // Bus clock enable: one clk_sys pulse every other cycle, changed away from posedge
    initial begin
        forever begin
            @(negedge clk_sys);
            ce = ~ce;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    function automatic logic [15:0] m_reg(input int r);
        case (r)
            0:       return 16'(m_done) << 7 | 16'(m_rx_ie) << 6;
            1:       return {m_ovr | m_frm, m_ovr, m_frm, 5'b00000, m_rbuf};
            2:       return 16'(m_ready) << 7 | 16'(m_tx_ie) << 6 | 16'(m_brk);
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_reset();
        m_done = 0; m_ovr = 0; m_frm = 0; m_rx_ie = 0;
        m_tx_ie = 0; m_brk = 0; m_ready = 1; m_rbuf = 8'h00;
    endtask

    task automatic model_rx(input bit [7:0] d, input bit stop);
        m_ovr  = m_done;
        m_frm  = ~stop;
        m_rbuf = d;
        m_done = 1;
    endtask

    task automatic model_rbuf_read();
        m_done = 0; m_ovr = 0; m_frm = 0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic bus_begin(input logic [15:0] addr, input bit we, input logic [1:0] wtbt,
                             input logic [15:0] din, output logic [15:0] rdata,
                             output int nce, output bit acked);
        wait_cycles(1);
        bus_if.bus_addr = addr;
        bus_if.bus_we   = we;
        bus_if.bus_wtbt = wtbt;
        bus_if.bus_din  = din;
        bus_if.bus_sync = 1'b1;
        wait_cycles(1);
        bus_if.bus_stb = 1'b1;
        nce = 0; acked = 0; rdata = 16'h0000;
        for (int i = 0; i < 16 && !acked; i++) begin
            @(posedge clk_sys);
            if (ce) nce++;
            #1;
            if (bus_if.bus_ack) begin
                acked = 1;
                rdata = bus_if.bus_dout;
            end
        end
    endtask

    task automatic bus_end();
        bus_if.bus_stb = 1'b0;
        for (int i = 0; i < 16 && bus_if.bus_ack; i++) wait_cycles(1);
        bus_if.bus_sync = 1'b0;
        bus_if.bus_we   = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] addr, output logic [15:0] rdata,
                           output int nce, output bit acked);
        bus_begin(addr, 1'b0, 2'b11, 16'h0000, rdata, nce, acked);
        bus_end();
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [1:0] wtbt, input logic [15:0] din);
        logic [15:0] rd;
        int nce;
        bit ak;
        bus_begin(addr, 1'b1, wtbt, din, rd, nce, ak);
        bus_end();
    endtask

    task automatic send_rx(input bit [7:0] d, input bit stop);
        uart_rxd = 1'b0;
        wait_cycles(B);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = d[i];
            wait_cycles(B);
        end
        uart_rxd = stop;
        wait_cycles(B);
        uart_rxd = 1'b1;
        wait_cycles(B);
    endtask

    task automatic capture_tx(output bit found, output logic [9:0] bits);
        found = 0;
        bits  = 10'h3FF;
        for (int i = 0; i < 4 * B && !found; i++) begin
            wait_cycles(1);
            if (uart_txd === 1'b0) found = 1;
        end
        if (found) begin
            wait_cycles(B / 2);
            bits[0] = uart_txd;
            for (int k = 1; k < 10; k++) begin
                wait_cycles(B);
                bits[k] = uart_txd;
            end
        end
    endtask

    task automatic test_reset();
        logic [15:0] rd;
        int nce;
        bit ak;
        reset_n = 1'b0;
        wait_cycles(3);
        reset_n = 1'b1;
        model_reset();
        wait_cycles(1);
        n_cmp++; if (bus_if.bus_dout !== 16'h0000) begin n_err++; $display("FAIL reset_dout got=%h exp=0000", bus_if.bus_dout); end
        n_cmp++; if (bus_if.bus_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack got=%b exp=0", bus_if.bus_ack); end
        n_cmp++; if ({uart_txd, irq_rx, irq_tx} !== 3'b100) begin n_err++; $display("FAIL reset_lines txd/irq_rx/irq_tx got=%b exp=100", {uart_txd, irq_rx, irq_tx}); end
        do_read(A_XCSR, rd, nce, ak);
        n_cmp++; if (rd !== 16'o000200) begin n_err++; $display("FAIL reset_xcsr got=%o exp=000200", rd); end
        n_cmp++; if (!ak || nce != 2) begin n_err++; $display("FAIL ack_latency acked=%0b ce_count=%0d exp=1/2", ak, nce); end
        n_cmp++; if (bus_if.bus_ack !== 1'b0) begin n_err++; $display("FAIL ack_release got=%b exp=0", bus_if.bus_ack); end
        do_read(A_RCSR, rd, nce, ak);
        n_cmp++; if (rd !== m_reg(0)) begin n_err++; $display("FAIL reset_rcsr got=%o exp=%o", rd, m_reg(0)); end
        do_read(A_RBUF, rd, nce, ak);
        n_cmp++; if (rd !== m_reg(1)) begin n_err++; $display("FAIL reset_rbuf got=%o exp=%o", rd, m_reg(1)); end
        do_read(A_XCSR | 16'h0001, rd, nce, ak);
        n_cmp++; if (rd !== m_reg(2)) begin n_err++; $display("FAIL odd_addr_xcsr got=%o exp=%o", rd, m_reg(2)); end
        bus_begin(16'o177570, 1'b0, 2'b11, 16'h0000, rd, nce, ak);
        n_cmp++; if (ak || bus_if.bus_dout !== 16'h0000) begin n_err++; $display("FAIL unselected acked=%0b dout=%h exp=0/0000", ak, bus_if.bus_dout); end
        bus_end();
    endtask

    task automatic test_byte_enable();
        logic [15:0] rd;
        int nce;
        bit ak;
        do_write(A_RCSR, 2'b10, 16'o000100);
        do_read(A_RCSR, rd, nce, ak);
        n_cmp++; if (rd !== m_reg(0)) begin n_err++; $display("FAIL rcsr_hi_only got=%o exp=%o", rd, m_reg(0)); end
        do_write(A_RCSR, 2'b01, 16'o000100);
        m_rx_ie = 1;
        do_read(A_RCSR, rd, nce, ak);
        n_cmp++; if (rd !== m_reg(0)) begin n_err++; $display("FAIL rcsr_lo_ie got=%o exp=%o", rd, m_reg(0)); end
        do_write(A_XCSR, 2'b01, 16'o000100);
        m_tx_ie = 1;
        n_cmp++; if (irq_tx !== (m_tx_ie & m_ready)) begin n_err++; $display("FAIL irq_tx_on got=%b exp=%b", irq_tx, m_tx_ie & m_ready); end
        do_write(A_XCSR, 2'b11, 16'o000000);
        m_tx_ie = 0;
        n_cmp++; if (irq_tx !== 1'b0) begin n_err++; $display("FAIL irq_tx_off got=%b exp=0", irq_tx); end
    endtask

    task automatic test_tx(input bit [7:0] d);
        logic [15:0] rd;
        logic [9:0]  bits;
        int nce;
        bit ak, found;
        int lows;
        fork
            begin
                do_write(A_XBUF, 2'b11, {8'($urandom), d});
                m_ready = 0;
                do_read(A_XCSR, rd, nce, ak);
                n_cmp++; if (rd !== m_reg(2)) begin n_err++; $display("FAIL tx_busy_xcsr got=%o exp=%o", rd, m_reg(2)); end
                do_write(A_XBUF, 2'b11, {8'h00, ~d});
            end
            capture_tx(found, bits);
        join
        n_cmp++; if (!found || bits !== {1'b1, d, 1'b0}) begin n_err++; $display("FAIL tx_frame found=%0b got=%b exp=%b", found, bits, {1'b1, d, 1'b0}); end
        wait_cycles(2 * B);
        m_ready = 1;
        do_read(A_XCSR, rd, nce, ak);
        n_cmp++; if (rd !== m_reg(2)) begin n_err++; $display("FAIL tx_ready_back got=%o exp=%o", rd, m_reg(2)); end
        lows = 0;
        for (int i = 0; i < 12 * B; i++) begin
            wait_cycles(1);
            if (uart_txd !== 1'b1) lows++;
        end
        n_cmp++; if (lows != 0) begin n_err++; $display("FAIL tx_ignored_write low_cycles=%0d exp=0", lows); end
    endtask

    task automatic test_brk();
        logic [15:0] rd;
        int nce;
        bit ak;
        do_write(A_XCSR, 2'b01, 16'o000001);
        m_brk = 1;
        wait_cycles(3);
        n_cmp++; if (uart_txd !== 1'b0) begin n_err++; $display("FAIL brk_txd got=%b exp=0", uart_txd); end
        do_read(A_XCSR, rd, nce, ak);
        n_cmp++; if (rd !== m_reg(2)) begin n_err++; $display("FAIL brk_xcsr got=%o exp=%o", rd, m_reg(2)); end
        do_write(A_XCSR, 2'b01, 16'o000000);
        m_brk = 0;
        wait_cycles(3);
        n_cmp++; if (uart_txd !== 1'b1) begin n_err++; $display("FAIL brk_release got=%b exp=1", uart_txd); end
    endtask

    task automatic test_rx_basic();
        logic [15:0] rd, exp;
        int nce;
        bit ak;
        send_rx(8'hA5, 1'b1);
        model_rx(8'hA5, 1'b1);
        n_cmp++; if (irq_rx !== (m_rx_ie & m_done)) begin n_err++; $display("FAIL rx_irq got=%b exp=%b", irq_rx, m_rx_ie & m_done); end
        exp = m_reg(1);
        do_read(A_RBUF, rd, nce, ak);
        model_rbuf_read();
        n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL rx_rbuf got=%h exp=%h", rd, exp); end
        do_read(A_RCSR, rd, nce, ak);
        n_cmp++; if (rd !== m_reg(0) || irq_rx !== 1'b0) begin n_err++; $display("FAIL rx_done_clear rcsr=%o irq=%b exp=%o/0", rd, irq_rx, m_reg(0)); end
    endtask

    task automatic test_overrun_framing();
        logic [15:0] rd, exp;
        int nce;
        bit ak;
        bit [7:0] b1, b2, b3;
        b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
        send_rx(b1, 1'b1); model_rx(b1, 1'b1);
        send_rx(b2, 1'b1); model_rx(b2, 1'b1);
        exp = m_reg(1);
        do_read(A_RBUF, rd, nce, ak);
        model_rbuf_read();
        n_cmp++; if (rd !== (16'o140000 | {8'h00, b2}) || rd !== exp) begin n_err++; $display("FAIL overrun got=%o exp=%o", rd, exp); end
        send_rx(b3, 1'b0); model_rx(b3, 1'b0);
        exp = m_reg(1);
        do_read(A_RBUF, rd, nce, ak);
        model_rbuf_read();
        n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL framing got=%o exp=%o", rd, exp); end
        uart_rxd = 1'b0;
        wait_cycles(3);
        uart_rxd = 1'b1;
        wait_cycles(2 * B);
        do_read(A_RCSR, rd, nce, ak);
        n_cmp++; if (rd !== m_reg(0)) begin n_err++; $display("FAIL false_start got=%o exp=%o", rd, m_reg(0)); end
    endtask

    task automatic test_held_read();
        logic [15:0] rd, exp;
        int nce;
        bit ak;
        bit [7:0] b1, b2;
        b1 = 8'($urandom); b2 = 8'($urandom);
        send_rx(b1, 1'b1); model_rx(b1, 1'b1);
        exp = m_reg(1);
        bus_begin(A_RBUF, 1'b0, 2'b11, 16'h0000, rd, nce, ak);
        model_rbuf_read();
        n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL held_rbuf got=%h exp=%h", rd, exp); end
        send_rx(b2, 1'b1); model_rx(b2, 1'b1);
        bus_end();
        do_read(A_RCSR, rd, nce, ak);
        n_cmp++; if (rd !== m_reg(0)) begin n_err++; $display("FAIL held_single_clear got=%o exp=%o", rd, m_reg(0)); end
        exp = m_reg(1);
        do_read(A_RBUF, rd, nce, ak);
        model_rbuf_read();
        n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL held_second got=%o exp=%o", rd, exp); end
    endtask

    task automatic test_random_rx();
        logic [15:0] rd, exp, din;
        logic [1:0]  wtbt;
        int nce;
        bit ak, stop;
        bit [7:0] d;
        for (int n = 0; n < 6; n++) begin
            din  = 16'($urandom);
            wtbt = 2'($urandom_range(0, 3));
            do_write(A_RCSR, wtbt, din);
            if (wtbt[0]) m_rx_ie = din[6];
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send_rx(d, stop);
            model_rx(d, stop);
            n_cmp++; if (irq_rx !== (m_rx_ie & m_done)) begin n_err++; $display("FAIL rand_irq_rx iter=%0d got=%b exp=%b", n, irq_rx, m_rx_ie & m_done); end
            if ($urandom_range(0, 1) == 1) begin
                exp = m_reg(1);
                do_read(A_RBUF, rd, nce, ak);
                model_rbuf_read();
                n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL rand_rbuf iter=%0d got=%o exp=%o", n, rd, exp); end
            end
            do_read(A_RCSR, rd, nce, ak);
            n_cmp++; if (rd !== m_reg(0)) begin n_err++; $display("FAIL rand_rcsr iter=%0d got=%o exp=%o", n, rd, m_reg(0)); end
        end
    endtask

    task automatic test_reset_mid_tx();
        logic [15:0] rd;
        int nce;
        bit ak;
        do_write(A_XCSR, 2'b01, 16'o000100);
        m_tx_ie = 1;
        do_write(A_XBUF, 2'b01, 16'h0000);
        m_ready = 0;
        wait_cycles(3 * B);
        n_cmp++; if (uart_txd !== 1'b0 || irq_tx !== 1'b0) begin n_err++; $display("FAIL pre_reset_frame txd=%b irq_tx=%b exp=0/0", uart_txd, irq_tx); end
        reset_n = 1'b0;
        wait_cycles(1);
        n_cmp++; if (uart_txd !== 1'b1 || irq_tx !== 1'b0) begin n_err++; $display("FAIL reset_mid_tx txd=%b irq_tx=%b exp=1/0", uart_txd, irq_tx); end
        reset_n = 1'b1;
        model_reset();
        do_read(A_XCSR, rd, nce, ak);
        n_cmp++; if (rd !== m_reg(2)) begin n_err++; $display("FAIL reset_mid_tx_xcsr got=%o exp=%o", rd, m_reg(2)); end
    endtask

    initial begin
        bus_if.bus_addr = 16'h0000;
        bus_if.bus_sync = 1'b0;
        bus_if.bus_stb  = 1'b0;
        bus_if.bus_we   = 1'b0;
        bus_if.bus_wtbt = 2'b00;
        bus_if.bus_din  = 16'h0000;
        model_reset();
        test_reset();
        test_byte_enable();
        test_tx(8'h55);
        test_tx(8'($urandom));
        test_tx(8'($urandom));
        test_brk();
        test_rx_basic();
        test_overrun_framing();
        test_held_read();
        test_random_rx();
        test_reset_mid_tx();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
